// File: rtl/multiplicador_sequencial_8bits.sv
// Unsigned shift-and-add multiplier: LARGURA x LARGURA -> 2*LARGURA bits in a fixed
// LARGURA cycles, with a start/ready handshake towards the control unit.
module multiplicador_sequencial_8bits #(
    parameter int LARGURA = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [LARGURA-1:0]     A,
    input  logic [LARGURA-1:0]     B,
    output logic [2*LARGURA-1:0]   produto,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   estouro
);

    localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [CW-1:0] CNT_ULTIMO = CW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    estado_t                 estado_q;
    logic [LARGURA-1:0]      mcand_q;
    logic [LARGURA-1:0]      acc_q;
    logic [LARGURA-1:0]      mplr_q;
    logic [CW-1:0]           cnt_q;
    logic [2*LARGURA-1:0]    produto_q;
    logic                    ocupado_q;
    logic                    pronto_q;
    logic                    estouro_q;

    // soma[LARGURA] is the carry that gets shifted back into the accumulator MSB.
    logic [LARGURA:0]        soma;
    logic [LARGURA-1:0]      acc_d;
    logic [LARGURA-1:0]      mplr_d;
    logic [2*LARGURA-1:0]    produto_d;

    always_comb begin
        soma      = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(LARGURA+1){1'b0}});
        acc_d     = soma[LARGURA:1];
        mplr_d    = {soma[0], mplr_q[LARGURA-1:1]};
        produto_d = {acc_d, mplr_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            estouro_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO, PRONTO: begin
                    pronto_q <= 1'b0;
                    if (inicio) begin
                        mcand_q   <= A;
                        mplr_q    <= B;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= CALCULA;
                    end else begin
                        estado_q  <= OCIOSO;
                    end
                end
                CALCULA: begin
                    // inicio is deliberately not looked at here: no restart mid-run.
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CNT_ULTIMO) begin
                        produto_q <= produto_d;
                        estouro_q <= |produto_d[2*LARGURA-1:LARGURA];
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                        estado_q  <= PRONTO;
                    end
                end
                default: begin
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign produto = produto_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;
    assign estouro = estouro_q;

endmodule
